apb_requester: RTL and testbench
================================

# apb_requester

APB requester (bus initiator) that turns a simple valid/ready request stream into APB3 SETUP/ACCESS transfers toward up to `SEL_COUNT` APB responders. Examples of responders are the board controller, UART and SD peripherals. It decodes the target responder from the upper address bits and waits on that responder's PREADY, with a bounded timeout. It returns read data, or an error, on a valid/ready response channel. It sits between the CPU-side peripheral port and the APB peripheral cluster in the `clk_cpu` domain.

## Interface
- `ADDR_WIDTH`, 16: width of request address and PADDR.
- `SEL_COUNT`, 4: number of APB responders (PSEL lines), 1..16, not necessarily a power of two.
- `SEL_SHIFT`, 12: lowest address bit of the responder index field; index = `addr[SEL_SHIFT +: $clog2(SEL_COUNT)]` (0 bits when SEL_COUNT=1 → index 0).
- `TIMEOUT`, 255: maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.
- `clk_cpu`  in  1  clock.
- `nreset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when valid&ready.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when valid&ready.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_error`  out  1  1 = timeout or undecodable address.
- `apb_PADDR`  out  ADDR_WIDTH  full latched address.
- `apb_PSEL`  out  SEL_COUNT  one-hot select.
- `apb_PENABLE`  out  1  ACCESS phase.
- `apb_PWRITE`  out  1  transfer direction.
- `apb_PWDATA`  out  32  write data.
- `apb_PREADY`  in  SEL_COUNT  per-responder ready.
- `apb_PRDATA`  in  SEL_COUNT*32  per-responder read data; responder i at bits `[32*i +: 32]`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On handshake, latch addr/write/wdata into `apb_PADDR`/`apb_PWRITE`/`apb_PWDATA`, latch index, clear timeout counter.
  - If index < SEL_COUNT, go to SETUP.
  - Otherwise set `rsp_error`=1 and `rsp_rdata`=0, then go to RESP with no APB activity.
- SETUP: `apb_PSEL[index]`=1, `apb_PENABLE`=0, for exactly one cycle, then go to ACCESS.
- ACCESS: `apb_PSEL[index]`=1, `apb_PENABLE`=1. Only `apb_PREADY[index]` and `apb_PRDATA[index]` are observed; other responders' lines are ignored.
  - PREADY=1: capture PRDATA into `rsp_rdata` for a read, or 0 for a write; `rsp_error`=0; go to RESP.
  - PREADY=0 and counter == TIMEOUT-1 (TIMEOUT≠0): `rsp_error`=1, `rsp_rdata`=0, go to RESP.
  - Otherwise increment the counter and stay. PREADY in the final timeout cycle wins: the transfer completes without error.
- RESP: `rsp_valid`=1, PSEL/PENABLE=0. `rsp_rdata`/`rsp_error` stay stable until `rsp_ready`, then go to IDLE.
- `req_ready`=1 only in IDLE; no request is accepted while a transfer or response is pending.
- `apb_PADDR`/`apb_PWRITE`/`apb_PWDATA` change only on request acceptance. They are stable from SETUP through ACCESS and hold their values in RESP and IDLE.
- Timeout counter width is `$clog2(TIMEOUT+1)`; it never wraps, because it is cleared on acceptance and bounded by TIMEOUT-1.

## Timing
- All outputs are registered.
- Reset (`nreset`=0 at a clk_cpu edge):
  - state ← IDLE; all outputs ← 0, including `req_ready`=0 while `nreset` is low.
  - `req_ready`=1 from the first edge with `nreset`=1.
  - Reset mid-transfer drops PSEL/PENABLE at that edge; the in-flight response is discarded.
- Zero-wait read or write, with request accepted at edge T:
  - PSEL high after T (SETUP), PENABLE high after T+1.
  - PREADY is sampled at T+2.
  - `rsp_valid` high after T+2.
  - With `rsp_ready`=1 at T+3, IDLE after T+3, so the next acceptance is at T+4. Throughput is 1 transfer per 4 cycles.
- N wait states add N cycles of ACCESS.
- Undecodable address: `rsp_valid` high after T; PSEL never asserts.
- Timeout: ACCESS lasts exactly TIMEOUT cycles; PSEL/PENABLE drop together with `rsp_valid` rising.

## Test plan
- Read 0x1008, `apb_PRDATA[1]`=0x05479D18, PREADY[1]=1 → PSEL=4'b0010 for 2 cycles, PENABLE in 2nd only, `rsp_valid` 3 cycles after accept, rdata=0x05479D18, error=0.
- Write 0x0000 data 0x5, PREADY[0] low for 3 ACCESS cycles → PENABLE held 4 cycles, PADDR/PWDATA/PWRITE stable throughout, rsp rdata=0, error=0.
- TIMEOUT=8, responder never ready → exactly 8 ACCESS cycles, PSEL drops with `rsp_valid`, error=1, rdata=0. Repeat with PREADY in the 8th cycle → error=0.
- SEL_COUNT=3, read 0x3000 → no PSEL bit ever set, `rsp_valid` one cycle after accept, error=1.
- Hold `rsp_ready`=0 for 5 cycles while `req_valid`=1 → rsp fields stable, `req_ready`=0, second request accepted only after the response handshake.
- `nreset`=0 for one cycle during ACCESS → next edge PSEL=0, PENABLE=0, `rsp_valid`=0, `req_ready`=0; `req_ready`=1 after release; a new read completes normally.

Source files
------------

// File: rtl/apb_requester_if.sv
// Bus bundle for apb_requester: request/response stream toward the CPU side
// and the APB3 initiator signals toward the responder cluster.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_COUNT  = 4
);
  // request channel
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [31:0]             req_wdata;
  // response channel
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_rdata;
  logic                    rsp_error;
  // APB3 initiator side
  logic [ADDR_WIDTH-1:0]   apb_PADDR;
  logic [SEL_COUNT-1:0]    apb_PSEL;
  logic                    apb_PENABLE;
  logic                    apb_PWRITE;
  logic [31:0]             apb_PWDATA;
  logic [SEL_COUNT-1:0]    apb_PREADY;
  logic [SEL_COUNT*32-1:0] apb_PRDATA;

  // requester (this block)
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
           apb_PREADY, apb_PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );

  // surroundings: CPU port plus responders
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
           apb_PREADY, apb_PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );
endinterface

// File: rtl/apb_requester.sv
// APB3 requester: converts a valid/ready request stream into SETUP/ACCESS
// transfers, decodes the responder from upper address bits, bounds the wait
// on PREADY and returns read data or an error on the response channel.
module apb_requester #(
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_COUNT  = 4,
  parameter int SEL_SHIFT  = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk_cpu,
  input  logic            nreset,
  apb_requester_if.master bus
);

  localparam int IDX_BITS = $clog2(SEL_COUNT);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [SEL_COUNT-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;

  logic [IDX_W-1:0]      req_idx;
  logic                  req_hit;
  logic [SEL_COUNT-1:0]  sel_onehot;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;
  logic                  timeout_hit;

  // Responder index straight from the incoming address; a single responder
  // has no index field at all.
  generate
    if (IDX_BITS == 0) begin : g_idx_none
      assign req_idx = '0;
    end else begin : g_idx_field
      assign req_idx = bus.req_addr[SEL_SHIFT +: IDX_BITS];
    end
  endgenerate

  // Non-power-of-two counts leave index codes with no responder behind them.
  assign req_hit    = ({1'b0, req_idx} < (IDX_W+1)'(SEL_COUNT));
  assign sel_onehot = SEL_COUNT'(1) << req_idx;

  // A timeout of 0 means wait for PREADY forever.
  generate
    if (TIMEOUT == 0) begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end else begin : g_tmo
      assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

  // Pick the latched responder's PREADY/PRDATA; all other lanes are ignored.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < SEL_COUNT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pready_sel = bus.apb_PREADY[i];
        prdata_sel = bus.apb_PRDATA[32*i +: 32];
      end
    end
  end

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    unique case (state_q)
      IDLE: begin
        // req_ready comes up one edge after reset release, then stays up here
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          paddr_d     = bus.req_addr;
          pwrite_d    = bus.req_write;
          pwdata_d    = bus.req_wdata;
          idx_d       = req_idx;
          cnt_d       = '0;
          if (req_hit) begin
            psel_d  = sel_onehot;
            state_d = SETUP;
          end else begin
            // no responder: answer with an error, never touch the bus
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over the timeout in the last allowed cycle
        if (pready_sel) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'h0 : prdata_sel;
          state_d     = RESP;
        end else if (timeout_hit) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything including req_ready.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.apb_PADDR   = paddr_q;
  assign bus.apb_PWRITE  = pwrite_q;
  assign bus.apb_PWDATA  = pwdata_q;
  assign bus.apb_PSEL    = psel_q;
  assign bus.apb_PENABLE = penable_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed cases then randomized transactions, each
// checked against a transaction-level model of latency, select and response.
module tb_apb_requester;
  localparam int AW = 16;
  localparam int SC = 3;
  localparam int SS = 12;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  apb_requester_if #(.ADDR_WIDTH(AW), .SEL_COUNT(SC)) bus();

  apb_requester #(.ADDR_WIDTH(AW), .SEL_COUNT(SC), .SEL_SHIFT(SS), .TIMEOUT(TO)) dut (
    .clk_cpu(clk),
    .nreset (nrst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // junk on responders that are not addressed; the DUT must ignore it
  task automatic set_noise(input int skip);
    for (int i = 0; i < SC; i++) begin
      if (i != skip) begin
        bus.apb_PREADY[i]          = 1'($urandom);
        bus.apb_PRDATA[32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transfer: responder holds PREADY low for 'waits' ACCESS cycles, then
  // high; response is held back for 'hold' cycles with a competing request.
  task automatic run_txn(input logic [15:0] addr, input bit wr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input int hold);
    int          idx, exp_acc, acc, rsp_at;
    bit          bad, tmo;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [SC-1:0] exp_psel;
    idx       = int'(addr[SS +: 2]);
    bad       = (idx >= SC);
    tmo       = !bad && (waits >= TO);
    exp_acc   = bad ? 0 : (tmo ? TO : waits + 1);
    exp_err   = bad || tmo;
    exp_rdata = (exp_err || wr) ? 32'h0 : rd;
    exp_psel  = bad ? '0 : SC'(1 << idx);

    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_write  = wr;
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b0;
    bus.apb_PREADY = '0;
    if (!bad) bus.apb_PRDATA[32*idx +: 32] = rd;
    set_noise(bad ? -1 : idx);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_wdata = $urandom;

    acc    = 0;
    rsp_at = 0;
    for (int k = 1; k <= 40 && rsp_at == 0; k++) begin
      chk("paddr", bus.apb_PADDR, addr);
      chk("pwrite", bus.apb_PWRITE, wr);
      chk("pwdata", bus.apb_PWDATA, wd);
      if (bus.rsp_valid) begin
        rsp_at = k;
      end else begin
        if (k == 1 && !bad) begin
          chk("setup_psel", bus.apb_PSEL, exp_psel);
          chk("setup_penable", bus.apb_PENABLE, 0);
        end else begin
          chk("psel", bus.apb_PSEL, exp_psel);
        end
        if (bus.apb_PENABLE) begin
          acc++;
          if (!bad) bus.apb_PREADY[idx] = (acc == waits + 1);
        end
        set_noise(bad ? -1 : idx);
        tick();
      end
    end
    if (rsp_at == 0) begin
      chk("rsp_never_valid", 0, 1);
      return;
    end
    chk("rsp_latency", rsp_at, bad ? 1 : 2 + exp_acc);
    chk("access_cycles", acc, exp_acc);
    chk("rsp_psel", bus.apb_PSEL, 0);
    chk("rsp_penable", bus.apb_PENABLE, 0);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("rsp_error", bus.rsp_error, exp_err);
    chk("rsp_req_ready", bus.req_ready, 0);

    bus.apb_PREADY = '0;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 16'($urandom);
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_rdata", bus.rsp_rdata, exp_rdata);
      chk("hold_error", bus.rsp_error, exp_err);
      chk("hold_paddr", bus.apb_PADDR, addr);
      chk("hold_psel", bus.apb_PSEL, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_req_ready", bus.req_ready, 1);
    chk("done_paddr", bus.apb_PADDR, addr);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_write  = 1'b0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus.apb_PREADY = '0;
    bus.apb_PRDATA = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_psel", bus.apb_PSEL, 0);
    chk("rst_penable", bus.apb_PENABLE, 0);
    chk("rst_paddr", bus.apb_PADDR, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    nrst = 1'b1;
    tick();

    // directed cases
    run_txn(16'h1008, 1'b0, 32'h0, 0, 32'h05479D18, 0);
    run_txn(16'h0000, 1'b1, 32'h5, 3, 32'hDEADBEEF, 0);
    run_txn(16'h2004, 1'b0, 32'h0, 100, 32'h12345678, 0);
    run_txn(16'h2004, 1'b0, 32'h0, 7, 32'hCAFE0001, 0);
    run_txn(16'h3000, 1'b0, 32'h0, 0, 32'h11111111, 0);
    run_txn(16'h1010, 1'b1, 32'hA5A5A5A5, 2, 32'h0, 5);

    // reset during ACCESS
    bus.req_valid  = 1'b1;
    bus.req_addr   = 16'h1000;
    bus.req_write  = 1'b0;
    bus.apb_PREADY = '0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("mid_penable", bus.apb_PENABLE, 1);
    nrst = 1'b0;
    tick();
    chk("mid_rst_psel", bus.apb_PSEL, 0);
    chk("mid_rst_penable", bus.apb_PENABLE, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    nrst = 1'b1;
    tick();
    chk("mid_rel_req_ready", bus.req_ready, 1);
    run_txn(16'h1020, 1'b0, 32'h0, 1, 32'h600DF00D, 0);

    // randomized transfers
    repeat (60) begin
      run_txn(16'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 10)),
              $urandom, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
